// File: rtl/fir_coeff_sched_if.sv
// Coefficient beat stream into fir_coeff_sched: plain valid/ready, one beat per accepted cycle.
// The master side supplies beats; the scheduler is the slave and owns coeffReady.
interface fir_coeff_sched_if #(
  parameter int COEFF_W = 16
);
  logic               coeffValid;
  logic [COEFF_W-1:0] coeffData;
  logic               coeffReady;

  modport master (output coeffValid, output coeffData, input  coeffReady);
  modport slave  (input  coeffValid, input  coeffData, output coeffReady);
endinterface

// File: rtl/fir_coeff_sched.sv
// Coefficient loader and per-sample read sequencer for the 4-bank coefficient RAM of the transposed FIR.
// Optional feature: define FIR_COEFF_CHECKSUM_EN to add the oChecksum running-sum port.
module fir_coeff_sched #(
  parameter int NUM_TAPS   = 33,
  parameter int BANK_DEPTH = 10,
  parameter int COEFF_W    = 16,
  parameter int READ_CYC   = 10
) (
  input  logic               iClk_12M,
  input  logic               iRst,
  input  logic               iEnSample_300k,
  input  logic               iUpdateReq,
  fir_coeff_sched_if.slave   coeff,
  output logic               oCoeffiUpdateFlag,
  output logic               oCsnRam,
  output logic               oWrnRam,
  output logic [3:0]         oAddrRam,
  output logic [COEFF_W-1:0] oWrDtRam,
  output logic [5:0]         oNumOfCoeff,
  output logic               oLoaded,
  output logic               oDone,
  output logic               oOverrun
`ifdef FIR_COEFF_CHECKSUM_EN
  ,
  output logic [COEFF_W+5:0] oChecksum
`endif
);

  localparam logic [5:0] LAST_BEAT = 6'(NUM_TAPS - 1);
  localparam logic [5:0] BURST_TAG = 6'(NUM_TAPS + READ_CYC - 1);
  localparam logic [3:0] LAST_WORD = 4'(BANK_DEPTH);
  localparam logic [3:0] LAST_READ = 4'(READ_CYC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } stateT;

  stateT              state, stateNxt;
  logic [5:0]         beatCnt, beatNxt;
  logic [3:0]         wordCnt, wordNxt;   // bank address the next accepted beat lands on
  logic [3:0]         burstCnt, burstNxt; // address shown this cycle; 0 means no burst
  logic               pending, pendingNxt;
  logic               finalWr, finalWrNxt;
  logic               readyNxt, flagNxt, csnNxt, wrnNxt, loadedNxt, doneNxt, overrunNxt;
  logic [3:0]         addrNxt;
  logic [COEFF_W-1:0] dataNxt;
  logic [5:0]         numNxt;
  logic               accept, burstOn, burstLast, enterLoad;
`ifdef FIR_COEFF_CHECKSUM_EN
  logic [COEFF_W+5:0] sumNxt;
`endif

  assign accept    = coeff.coeffValid & coeff.coeffReady;
  assign burstOn   = (burstCnt != 4'd0);
  assign burstLast = (burstCnt == LAST_READ);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    stateNxt   = state;
    beatNxt    = beatCnt;
    wordNxt    = wordCnt;
    burstNxt   = burstCnt;
    pendingNxt = pending;
    finalWrNxt = 1'b0;
    readyNxt   = 1'b0;
    flagNxt    = 1'b0;
    csnNxt     = 1'b1;
    wrnNxt     = 1'b1;
    addrNxt    = oAddrRam;
    dataNxt    = oWrDtRam;
    numNxt     = oNumOfCoeff;
    loadedNxt  = oLoaded;
    doneNxt    = 1'b0;
    overrunNxt = 1'b0;
    enterLoad  = 1'b0;
`ifdef FIR_COEFF_CHECKSUM_EN
    sumNxt     = oChecksum;
`endif

    case (state)
      IDLE: begin
        enterLoad = iUpdateReq;
      end

      LOAD: begin
        pendingNxt = 1'b0;
        if (finalWr) begin
          stateNxt  = RUN;
          doneNxt   = 1'b1;
          loadedNxt = 1'b1;
        end else begin
          flagNxt  = 1'b1;
          readyNxt = 1'b1;
          if (accept) begin
            csnNxt  = 1'b0;
            wrnNxt  = 1'b0;
            addrNxt = wordCnt;
            dataNxt = coeff.coeffData;
            numNxt  = beatCnt;
            wordNxt = (wordCnt == LAST_WORD) ? 4'd1 : wordCnt + 4'd1;
`ifdef FIR_COEFF_CHECKSUM_EN
            sumNxt  = oChecksum + {{6{coeff.coeffData[COEFF_W-1]}}, coeff.coeffData};
`endif
            if (beatCnt == LAST_BEAT) begin
              readyNxt   = 1'b0;
              finalWrNxt = 1'b1;
            end else begin
              beatNxt = beatCnt + 6'd1;
            end
          end
        end
      end

      RUN: begin
        if (burstOn) begin
          overrunNxt = iEnSample_300k;
          if (burstLast) begin
            burstNxt = 4'd0;
            addrNxt  = 4'd0;
          end else begin
            burstNxt = burstCnt + 4'd1;
            csnNxt   = 1'b0;
            addrNxt  = burstCnt + 4'd1;
            numNxt   = BURST_TAG;
          end
        end
        // A reload waits for the burst in flight so one sample never sees two coefficient sets.
        if ((iUpdateReq || pending) && (!burstOn || burstLast)) begin
          enterLoad = 1'b1;
        end else if (iUpdateReq) begin
          pendingNxt = 1'b1;
        end else if (!burstOn && iEnSample_300k) begin
          burstNxt = 4'd1;
          csnNxt   = 1'b0;
          addrNxt  = 4'd1;
          numNxt   = BURST_TAG;
        end
      end

      default: begin
        stateNxt = IDLE;
      end
    endcase

    if (enterLoad) begin
      stateNxt   = LOAD;
      flagNxt    = 1'b1;
      readyNxt   = 1'b1;
      loadedNxt  = 1'b0;
      beatNxt    = 6'd0;
      wordNxt    = 4'd1;
      pendingNxt = 1'b0;
`ifdef FIR_COEFF_CHECKSUM_EN
      sumNxt     = '0;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      state             <= IDLE;
      beatCnt           <= 6'd0;
      wordCnt           <= 4'd1;
      burstCnt          <= 4'd0;
      pending           <= 1'b0;
      finalWr           <= 1'b0;
      coeff.coeffReady  <= 1'b0;
      oCoeffiUpdateFlag <= 1'b0;
      oCsnRam           <= 1'b1;
      oWrnRam           <= 1'b1;
      oAddrRam          <= 4'd0;
      oWrDtRam          <= '0;
      oNumOfCoeff       <= 6'd0;
      oLoaded           <= 1'b0;
      oDone             <= 1'b0;
      oOverrun          <= 1'b0;
`ifdef FIR_COEFF_CHECKSUM_EN
      oChecksum         <= '0;
`endif
    end else begin
      state             <= stateNxt;
      beatCnt           <= beatNxt;
      wordCnt           <= wordNxt;
      burstCnt          <= burstNxt;
      pending           <= pendingNxt;
      finalWr           <= finalWrNxt;
      coeff.coeffReady  <= readyNxt;
      oCoeffiUpdateFlag <= flagNxt;
      oCsnRam           <= csnNxt;
      oWrnRam           <= wrnNxt;
      oAddrRam          <= addrNxt;
      oWrDtRam          <= dataNxt;
      oNumOfCoeff       <= numNxt;
      oLoaded           <= loadedNxt;
      oDone             <= doneNxt;
      oOverrun          <= overrunNxt;
`ifdef FIR_COEFF_CHECKSUM_EN
      oChecksum         <= sumNxt;
`endif
    end
  end

endmodule
